avg_triplet_frontend: RTL

- Streaming wrapper that sits directly upstream and downstream of the 3-stage averaging pipeline.
- Upstream: accepts a serial 8-bit sample stream (valid/ready), packs every three samples into a triple and drives the pipeline's a/b/c inputs for one issue cycle.
- Downstream: tracks pipeline latency with a valid shadow shift register, captures each avg result into a small result FIFO and presents it on an out valid/ready interface.
- Credit control guarantees no result is lost; the pipeline itself cannot stall.

---
 rtl/avg_pkg.sv | 6 +
 rtl/avg_result_fifo.sv | 58 +++++
 rtl/avg_triplet_frontend.sv | 107 ++++++++++
 3 files changed

// File: rtl/avg_pkg.sv
// Shared types and defaults for the averaging-pipeline front end.
package avg_pkg;
  typedef logic [7:0] sample_t;
  typedef enum logic [1:0] {COLL_A, COLL_B, COLL_C} coll_state_e;
  localparam int unsigned AVG_PIPE_LAT = 3;
endpackage

// File: rtl/avg_result_fifo.sv
// First-word-fall-through result FIFO with registered head/valid outputs.
module avg_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] head_next;
  logic             wr, rd;

  assign in_ready = (count != CW'(DEPTH)) || out_ready;
  assign wr       = in_valid && in_ready;
  assign rd       = out_valid && out_ready;

  // A write only becomes the new head when it lands in the slot the read pointer moves to.
  always_comb begin
    rd_next    = rd ? rd_ptr + AW'(1) : rd_ptr;
    count_next = count;
    if (wr && !rd)      count_next = count + CW'(1);
    else if (!wr && rd) count_next = count - CW'(1);
    head_next = '0;
    if (count_next != '0)
      head_next = (wr && (wr_ptr == rd_next)) ? in_data : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      out_data  <= head_next;
    end
  end
endmodule

// File: rtl/avg_triplet_frontend.sv
// Packs serial samples into triples for the averaging pipeline and buffers its results.
// Optional synchronous flush input enabled by defining TRIPLET_FLUSH_EN.
module avg_triplet_frontend
  import avg_pkg::*;
#(
  parameter int unsigned PIPE_LAT   = AVG_PIPE_LAT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
`ifdef TRIPLET_FLUSH_EN
  input  logic    flush,
`endif
  input  logic    in_valid,
  output logic    in_ready,
  input  sample_t in_data,
  output sample_t a,
  output sample_t b,
  output sample_t c,
  input  sample_t avg,
  output logic    out_valid,
  input  logic    out_ready,
  output sample_t out_data
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  coll_state_e         state;
  sample_t             hold_a, hold_b;
  logic                issue;
  logic [PIPE_LAT-1:0] shadow;
  logic [CW-1:0]       credits;
  logic                flush_act, accept, take, pop, fifo_wr_ready;

`ifdef TRIPLET_FLUSH_EN
  assign flush_act = flush && (state != COLL_A);
`else
  assign flush_act = 1'b0;
`endif

  assign in_ready = !flush_act && ((state != COLL_C) || (credits != '0));
  assign accept   = in_valid && in_ready;
  assign take     = accept && (state == COLL_C);
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= COLL_A;
      hold_a  <= '0;
      hold_b  <= '0;
      a       <= '0;
      b       <= '0;
      c       <= '0;
      issue   <= 1'b0;
      credits <= CW'(FIFO_DEPTH);
    end else begin
      issue <= 1'b0;
      if (flush_act) begin
        state <= COLL_A;
      end else if (accept) begin
        case (state)
          COLL_A: begin
            hold_a <= in_data;
            state  <= COLL_B;
          end
          COLL_B: begin
            hold_b <= in_data;
            state  <= COLL_C;
          end
          COLL_C: begin
            a     <= hold_a;
            b     <= hold_b;
            c     <= in_data;
            issue <= 1'b1;
            state <= COLL_A;
          end
          default: state <= COLL_A;
        endcase
      end
      // Credits cover FIFO occupancy plus in-flight triples.
      if (pop && !take)      credits <= credits + CW'(1);
      else if (!pop && take) credits <= credits - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else begin
      shadow[0] <= issue;
      for (int unsigned i = 1; i < PIPE_LAT; i++) shadow[i] <= shadow[i-1];
    end
  end

  avg_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (shadow[PIPE_LAT-1] && fifo_wr_ready),
    .in_ready  (fifo_wr_ready),
    .in_data   (avg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );
endmodule
